spi_slv_reg_bridge: RTL and testbench
=====================================

Name: spi_slv_reg_bridge

Overview:
- SPI slave front end that decodes serial frames from the external host into single-cycle register-bus accesses.
- Drives wen/ren/addr/wdata into the rw_reg register bank, which sits directly downstream.
- Returns the bank's OR-combined read data on MISO.
- Everything runs on i_clk; the SPI pins are oversampled, not used as clocks.

Parameters:
- DW, 8, register data width.
- AW, 8, register address width.
- FRM_LEN, 1+AW+DW (17), bits per frame: 1 R/W bit, then AW address bits, then DW data bits, all MSB first.
- CNT_W, $clog2(FRM_LEN+2), width of the bit counter (one extra count reserved for overrun detection).

Ports:
- i_clk  in  1  system clock; must be at least 6x SCLK frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to i_clk.
- i_csb  in  1  SPI chip select, active low, asynchronous.
- i_mosi  in  1  SPI serial data in.
- o_miso  out  1  SPI serial data out.
- o_miso_oe  out  1  MISO pad output enable.
- o_wen  out  1  register write strobe, one i_clk cycle.
- o_ren  out  1  register read strobe, one i_clk cycle.
- o_addr  out  AW  register address.
- o_wdata  out  DW  register write data.
- i_rdata  in  DW  OR of all register o_rdata outputs; valid combinationally in the o_ren cycle.
- o_frm_err  out  1  one-cycle pulse on a length-error frame.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: every output is 0; the FSM is in IDLE.
- Synchronisation: i_sclk, i_csb and i_mosi each pass through a 2-flop synchroniser. A third flop provides edge detection, giving sclk_rise, sclk_fall, csb_fall and csb_rise.
- Sampling and shifting:
  - MOSI is sampled on sclk_rise into a shift register; the bit counter then increments.
  - MISO shifts on sclk_fall.
- FSM states:
  - IDLE: on csb_fall, clear the counter and go to CMD. Any SCLK edges while in IDLE are ignored.
  - CMD: the first sclk_rise latches rw (1 = write, 0 = read) and moves to ADDR.
  - ADDR: after AW further rises, latch o_addr.
    - Read: pulse o_ren in the next cycle. Capture i_rdata in that same cycle into the tx shift register, then enter DATA.
    - Write: enter DATA.
  - DATA:
    - Read: o_miso_oe = 1. On each sclk_fall, present the next rdata bit MSB first; the first bit is driven on the fall that follows the last address rise.
    - Write: after DW rises, latch o_wdata and pulse o_wen in the next cycle, then go to DONE.
    - After DW data rises on a read, go to DONE.
  - DONE: the FSM waits here until csb_rise, then returns to IDLE.
- Strobe timing: o_addr and o_wdata are stable from the cycle before the strobe until the next frame's address latch. o_wen and o_ren never assert together.
- MISO outside read DATA: o_miso = 0 and o_miso_oe = 0.
- Short frame: csb_rise in any state other than IDLE or DONE aborts the frame.
  - No o_wen is issued.
  - An o_ren that was already issued stands.
  - o_frm_err pulses once and the FSM returns to IDLE.
- Overrun: any sclk_rise in DONE sets an overrun flag. On csb_rise, o_frm_err pulses. The access already performed is not undone.
- Simultaneous final bit and CS release: if the final data-bit sclk_rise and csb_rise are detected in the same cycle, the bit counts and the frame is complete. o_wen is issued with no error.
- Reset mid-frame: the frame is lost. The FSM stays in IDLE until a fresh csb_fall arrives, so a CSB held low through reset release starts nothing.
- Read timing constraint: half an SCLK period must be at least 3 i_clk cycles so rdata is captured before the first MISO fall.

Decomposition:
- Shared package spi_bridge_pkg holds:
  - the state enum typedef (IDLE, CMD, ADDR, DATA, DONE);
  - the R/W bit encoding constants RW_WR = 1 and RW_RD = 0;
  - a function that computes FRM_LEN from AW and DW.
- One sub-module, spi_in_sync: a per-bit 2-flop synchroniser plus edge detector with outputs level, rise and fall. It is instantiated for sclk, csb and mosi (mosi uses level only).

Test Plan:
- Write frame rw=1, addr 0x12, data 0xA5 → exactly one o_wen pulse with o_addr = 0x12 and o_wdata = 0xA5; o_ren stays 0; o_frm_err stays 0.
- Read frame rw=0, addr 0x34, with i_rdata = 0x5C during o_ren → one o_ren pulse with o_addr = 0x34. MISO sampled on the 8 data rises reads 0,1,0,1,1,1,0,0. o_miso_oe is high only during the data phase.
- Short write (CSB released after 10 bits) → no o_wen, one o_frm_err pulse, o_busy returns to 0; the next full frame executes normally.
- Overrun write of 20 bits, addr 0x01, data 0xFF → one o_wen at the 17th bit with wdata 0xFF, then one o_frm_err at CSB release.
- i_rst_n asserted at bit 9 of a write with CSB kept low through the frame end → no o_wen, all outputs 0. A following clean frame (addr 0x02, data 0x3C) writes correctly.
- Back-to-back frames with CSB high for 2 SCLK periods, write 0x10/0x11 then read 0x10 → two o_wen pulses, then o_ren; MISO returns the i_rdata value supplied.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-slave to register-bus bridge.
// Holds the frame FSM state encoding, the R/W command bit encoding and
// a helper that derives the frame length from the field widths.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    // First bit of every frame selects the access direction.
    localparam logic RW_WR = 1'b1;
    localparam logic RW_RD = 1'b0;

    // One R/W bit, then the address field, then the data field.
    function automatic int frm_len(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/spi_slv_reg_bridge_sync.sv
// Two-flop synchroniser for one asynchronous pin, followed by a third flop
// used purely for edge detection.
// Ports:
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_d            : asynchronous input pin
//   o_level        : synchronised level
//   o_rise/o_fall  : one-cycle pulses on a synchronised edge
// All flops reset to 0 so a pin that is already low at reset release never
// produces a falling edge.
module spi_in_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability chain plus the delayed copy for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slv_reg_bridge.sv
// SPI mode-0 slave that turns each serial frame (R/W, address, data; MSB
// first) into a single-cycle register-bus access, and returns read data on
// MISO. SCLK/CSB/MOSI are oversampled on i_clk.
// Ports:
//   i_clk, i_rst_n             : system clock, async active-low reset
//   i_sclk, i_csb, i_mosi      : SPI pins (asynchronous)
//   o_miso, o_miso_oe          : SPI data out and pad enable
//   o_wen, o_ren               : one-cycle register strobes
//   o_addr, o_wdata            : register address / write data
//   i_rdata                    : OR-combined register read data (valid with o_ren)
//   o_frm_err                  : one-cycle pulse on a short or overrun frame
//   o_busy                     : high while a frame is being handled
module spi_slv_reg_bridge
    import spi_bridge_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int FRM_LEN = frm_len(AW, DW),
    parameter int CNT_W   = $clog2(FRM_LEN + 2)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_sclk,
    input  logic          i_csb,
    input  logic          i_mosi,
    output logic          o_miso,
    output logic          o_miso_oe,
    output logic          o_wen,
    output logic          o_ren,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    input  logic [DW-1:0] i_rdata,
    output logic          o_frm_err,
    output logic          o_busy
);

    localparam int SH_W = (AW > DW) ? AW : DW;
    // Counter value seen on the last address rise and on the last data rise.
    localparam logic [CNT_W-1:0] C_ADDR_END = CNT_W'(AW);
    localparam logic [CNT_W-1:0] C_DATA_END = CNT_W'(AW + DW);
    // Saturation point: one past a complete frame is enough to flag overrun.
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(FRM_LEN + 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_csb_lvl, w_csb_rise, w_csb_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    spi_in_sync u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_in_sync u_sync_csb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_csb),
        .o_level(w_csb_lvl), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
    );

    spi_in_sync u_sync_mosi (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    // Levels of SCLK/CSB and MOSI edges are not needed by the frame logic.
    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_lvl, w_csb_lvl, w_mosi_rise, w_mosi_fall};

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [SH_W-1:0]   r_shift;
    logic [DW-1:0]     r_tx;
    logic              r_rw;
    logic              r_ovr;
    logic              r_rd_pend;
    logic              r_wr_pend;
    logic              r_wen, r_ren, r_frm_err, r_busy, r_miso, r_miso_oe;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;

    logic w_clr_frame, w_lat_rw, w_lat_addr, w_lat_wdata, w_rd_req;
    logic w_err, w_set_ovr;

    // Frame state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle control events.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_frame = 1'b0;
        w_lat_rw    = 1'b0;
        w_lat_addr  = 1'b0;
        w_lat_wdata = 1'b0;
        w_rd_req    = 1'b0;
        w_err       = 1'b0;
        w_set_ovr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_csb_fall) begin
                    w_clr_frame = 1'b1;
                    w_state_nxt = CMD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CMD: begin
                if (w_csb_rise) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_sclk_rise) begin
                    w_lat_rw    = 1'b1;
                    w_state_nxt = ADDR;
                end else begin
                    w_state_nxt = CMD;
                end
            end
            ADDR: begin
                if (w_csb_rise) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_sclk_rise && (r_cnt == C_ADDR_END)) begin
                    w_lat_addr  = 1'b1;
                    w_rd_req    = (r_rw == RW_RD);
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = ADDR;
                end
            end
            DATA: begin
                // A final bit arriving together with CS release still completes the frame.
                if (w_sclk_rise && (r_cnt == C_DATA_END)) begin
                    w_lat_wdata = (r_rw == RW_WR);
                    if (w_csb_rise) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end else if (w_csb_rise) begin
                    w_err       = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            DONE: begin
                if (w_csb_rise) begin
                    w_err       = r_ovr | w_sclk_rise;
                    w_state_nxt = IDLE;
                end else if (w_sclk_rise) begin
                    w_set_ovr   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: bit counter, shifters, latched fields and registered outputs.
    // Strobes are delayed one cycle behind the field latch so o_addr/o_wdata
    // are already stable in the cycle before o_ren/o_wen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_tx       <= '0;
            r_rw       <= 1'b0;
            r_ovr      <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_wen      <= 1'b0;
            r_ren      <= 1'b0;
            r_frm_err  <= 1'b0;
            r_busy     <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_rd_pend <= w_rd_req;
            r_ren     <= r_rd_pend;
            r_wr_pend <= w_lat_wdata;
            r_wen     <= r_wr_pend;
            r_frm_err <= w_err;
            r_busy    <= (w_state_nxt != IDLE);

            if (w_clr_frame) begin
                r_cnt <= '0;
            end else if (w_sclk_rise && (r_state != IDLE) && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_sclk_rise && (r_state != IDLE)) begin
                r_shift <= {r_shift[SH_W-2:0], w_mosi};
            end

            if (w_lat_rw) begin
                r_rw <= w_mosi;
            end

            if (w_lat_addr) begin
                r_addr <= {r_shift[AW-2:0], w_mosi};
            end

            if (w_lat_wdata) begin
                r_wdata <= {r_shift[DW-2:0], w_mosi};
            end

            if (w_clr_frame) begin
                r_ovr <= 1'b0;
            end else if (w_set_ovr) begin
                r_ovr <= 1'b1;
            end

            // Read data is captured in the o_ren cycle, then shifted out MSB first.
            if (r_ren) begin
                r_tx <= i_rdata;
            end else if (w_sclk_fall && (r_state == DATA) && (r_rw == RW_RD)) begin
                r_tx <= {r_tx[DW-2:0], 1'b0};
            end

            if ((r_state == DATA) && (r_rw == RW_RD)) begin
                r_miso_oe <= 1'b1;
                if (w_sclk_fall) begin
                    r_miso <= r_tx[DW-1];
                end
            end else begin
                r_miso_oe <= 1'b0;
                r_miso    <= 1'b0;
            end
        end
    end

    assign o_wen     = r_wen;
    assign o_ren     = r_ren;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_frm_err = r_frm_err;
    assign o_busy    = r_busy;
    assign o_miso    = r_miso;
    assign o_miso_oe = r_miso_oe;

endmodule

// File: tb/tb_spi_slv_reg_bridge.sv
// Bench for spi_slv_reg_bridge: acts as SPI host and as the downstream
// register bank. Expected results come from a frame-level model: a frame
// of n bits performs its access only if it reaches the relevant field, is
// erroneous unless n is exactly 17, and a read returns whatever the model
// register array holds for that address.
module tb_spi_slv_reg_bridge;

    localparam int HALF = 50;        // half SCLK period (5 i_clk cycles)
    localparam int GAP  = 4 * HALF;  // CSB high time between frames

    logic       i_clk, i_rst_n, i_sclk, i_csb, i_mosi;
    logic       o_miso, o_miso_oe, o_wen, o_ren, o_frm_err, o_busy;
    logic [7:0] o_addr, o_wdata, i_rdata;

    spi_slv_reg_bridge dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_csb(i_csb),
        .i_mosi(i_mosi), .o_miso(o_miso), .o_miso_oe(o_miso_oe),
        .o_wen(o_wen), .o_ren(o_ren), .o_addr(o_addr), .o_wdata(o_wdata),
        .i_rdata(i_rdata), .o_frm_err(o_frm_err), .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Register bank seen by the DUT, plus a preload port for the bench.
    logic [7:0] bank [256];
    logic       pre_en;
    logic [7:0] pre_addr, pre_data;
    assign i_rdata = o_ren ? bank[o_addr] : 8'h00;

    always @(posedge i_clk) begin
        if (o_wen) bank[o_addr] <= o_wdata;
        else if (pre_en) bank[pre_addr] <= pre_data;
    end

    // Model of the register contents.
    logic [7:0] model_mem [256];

    // Strobe monitor.
    int wen_cnt = 0, ren_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [7:0] wen_addr = 8'h00, wen_data = 8'h00, ren_addr = 8'h00;

    always @(negedge i_clk) begin
        if (o_wen) begin
            wen_cnt  <= wen_cnt + 1;
            wen_addr <= o_addr;
            wen_data <= o_wdata;
        end
        if (o_ren) begin
            ren_cnt  <= ren_cnt + 1;
            ren_addr <= o_addr;
        end
        if (o_frm_err) err_cnt <= err_cnt + 1;
        if (o_wen && o_ren) both_cnt <= both_cnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one frame of nbits; rst_at>=0 pulses reset before that bit;
    // simul releases CSB together with the last SCLK rise.
    task automatic run_frame(input logic rw, input logic [7:0] addr, input logic [7:0] data,
                             input int nbits, input int rst_at, input bit simul);
        logic [16:0] f;
        logic [7:0]  miso_b;
        logic        busy_mid;
        logic        rst_hit, exp_wen, exp_ren, exp_err, exp_oe;
        int          w0, r0, e0, oe_bad;
        f        = {rw, addr, data};
        miso_b   = 8'h00;
        busy_mid = 1'b0;
        oe_bad   = 0;
        rst_hit  = (rst_at >= 0) && (rst_at < nbits);
        exp_oe   = (rw == 1'b0) && !rst_hit;
        w0 = wen_cnt; r0 = ren_cnt; e0 = err_cnt;

        i_csb = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                i_rst_n = 1'b0;
                #30;
                i_rst_n = 1'b1;
            end
            i_mosi = (i < 17) ? f[16-i] : 1'($urandom);
            #HALF;
            if (i >= 9 && i < 17) begin
                miso_b = {miso_b[6:0], o_miso};
                if (o_miso_oe !== exp_oe) oe_bad++;
            end else if (i >= 1 && i <= 8) begin
                if (o_miso_oe !== 1'b0) oe_bad++;
            end
            if (i == 4) busy_mid = o_busy;
            i_sclk = 1'b1;
            if (simul && (i == nbits - 1)) i_csb = 1'b1;
            #HALF;
            i_sclk = 1'b0;
        end
        if (!simul) begin
            #HALF;
            i_csb = 1'b1;
        end
        i_mosi = 1'b0;
        #GAP;

        exp_wen = !rst_hit && (rw == 1'b1) && (nbits >= 17);
        exp_ren = !rst_hit && (rw == 1'b0) && (nbits >= 9);
        exp_err = !rst_hit && (nbits != 17);

        chk("wen_count", wen_cnt - w0, exp_wen ? 1 : 0);
        chk("ren_count", ren_cnt - r0, exp_ren ? 1 : 0);
        chk("frm_err_count", err_cnt - e0, exp_err ? 1 : 0);
        if (exp_wen) begin
            chk("wen_addr", wen_addr, addr);
            chk("wen_data", wen_data, data);
            model_mem[addr] = data;
        end
        if (exp_ren) chk("ren_addr", ren_addr, addr);
        if (exp_ren && nbits >= 17) chk("miso_data", miso_b, model_mem[addr]);
        if (!rst_hit && nbits > 4) chk("busy_mid", busy_mid, 1'b1);
        chk("miso_oe_phase", oe_bad, 0);
        chk("busy_after", o_busy, 1'b0);
        chk("miso_oe_after", o_miso_oe, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic       rw;
        logic [7:0] a, d;
        int         sel, nb;
        i_rst_n = 1'b0; i_sclk = 1'b0; i_csb = 1'b1; i_mosi = 1'b0;
        pre_en = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
        #3;
        // Clear the bank through the preload port; model starts equal.
        pre_en = 1'b1;
        for (int k = 0; k < 256; k++) begin
            pre_addr = 8'(k);
            pre_data = 8'h00;
            model_mem[k] = 8'h00;
            #10;
        end
        pre_en = 1'b0;
        #20;
        i_rst_n = 1'b1;
        #20;
        chk("rst_wen", o_wen, 1'b0);
        chk("rst_ren", o_ren, 1'b0);
        chk("rst_addr", o_addr, 8'h00);
        chk("rst_wdata", o_wdata, 8'h00);
        chk("rst_miso", o_miso, 1'b0);
        chk("rst_miso_oe", o_miso_oe, 1'b0);
        chk("rst_frm_err", o_frm_err, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        #GAP;

        // Basic write, then a read of a preloaded register.
        run_frame(1'b1, 8'h12, 8'hA5, 17, -1, 1'b0);
        pre_en = 1'b1; pre_addr = 8'h34; pre_data = 8'h5C; model_mem[8'h34] = 8'h5C;
        #10;
        pre_en = 1'b0;
        run_frame(1'b0, 8'h34, 8'h00, 17, -1, 1'b0);

        // Short write, then a normal frame.
        run_frame(1'b1, 8'h20, 8'h77, 10, -1, 1'b0);
        run_frame(1'b1, 8'h21, 8'h66, 17, -1, 1'b0);

        // Overrun write of 20 bits.
        run_frame(1'b1, 8'h01, 8'hFF, 20, -1, 1'b0);

        // Reset mid-frame with CSB held low to the end.
        run_frame(1'b1, 8'h05, 8'h99, 17, 9, 1'b0);
        chk("rstmid_wen", o_wen, 1'b0);
        chk("rstmid_ren", o_ren, 1'b0);
        chk("rstmid_addr", o_addr, 8'h00);
        chk("rstmid_wdata", o_wdata, 8'h00);
        chk("rstmid_miso", o_miso, 1'b0);
        chk("rstmid_frm_err", o_frm_err, 1'b0);
        run_frame(1'b1, 8'h02, 8'h3C, 17, -1, 1'b0);

        // Back-to-back write/write/read.
        run_frame(1'b1, 8'h10, 8'h11, 17, -1, 1'b0);
        run_frame(1'b1, 8'h11, 8'h10, 17, -1, 1'b0);
        run_frame(1'b0, 8'h10, 8'h00, 17, -1, 1'b0);

        // Final bit and CS release together, then read back.
        run_frame(1'b1, 8'h03, 8'h5A, 17, -1, 1'b1);
        run_frame(1'b0, 8'h03, 8'h00, 17, -1, 1'b0);

        // Randomized frames over a small address window for read-back hits.
        for (int n = 0; n < 40; n++) begin
            rw  = 1'($urandom);
            a   = 8'($urandom_range(0, 7));
            d   = 8'($urandom);
            sel = int'($urandom_range(0, 7));
            if (sel == 5) nb = int'($urandom_range(2, 16));
            else if (sel == 6) nb = int'($urandom_range(18, 20));
            else nb = 17;
            run_frame(rw, a, d, nb, -1, (sel == 7));
        end

        chk("wen_ren_overlap", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
